uart_tx_frame: RTL

Parametrised UART transmit framer: accepts characters over a valid/ready handshake and serialises each one as a start bit, data bits, optional parity, and stop bits, at one bit per `baud_clk` cycle. It sits between the host-side byte source and the `tx` pin in the UART project. It replaces the fixed 7/8-bit serialiser with the following features:
- runtime data length from 5 to DATA_W bits;
- internally computed parity (five modes);
- selectable bit order;
- break generation;
- back-to-back frames;
- an optional input FIFO.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_tx_fifo.sv | 57 +++++
 rtl/uart_tx_frame.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART transmit framer.
//   - tx_state_e : framer FSM states (3 bits)
//   - PAR_*      : parity mode encodings as seen on cfg_parity
//   - clamp_len  : maps an out-of-range runtime data length to the maximum
package uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP1  = 3'd4,
      S_STOP2  = 3'd5,
      S_BREAK  = 3'd6
   } tx_state_e;

   localparam logic [2:0] PAR_NONE  = 3'b000;
   localparam logic [2:0] PAR_EVEN  = 3'b001;
   localparam logic [2:0] PAR_ODD   = 3'b010;
   localparam logic [2:0] PAR_MARK  = 3'b011;
   localparam logic [2:0] PAR_SPACE = 3'b100;

   // Legal lengths are 5..max_w; anything else falls back to max_w.
   function automatic logic [3:0] clamp_len(input logic [3:0] len, input int max_w);
      if (len < 4'd5 || int'(len) > max_w) return 4'(max_w);
      return len;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous first-word fall-through FIFO feeding the framer.
//   baud_clk, arst_n : clock, async active-low reset (flushes pointers/level)
//   push, din        : write request and data (ignored while full)
//   pop              : consume head entry (ignored while empty)
//   dout             : head entry, valid whenever !empty
//   full, empty      : status flags
//   level            : current occupancy 0..DEPTH
module uart_tx_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                     baud_clk,
   input  logic                     arst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   lvl_q;
   logic          push_ok, pop_ok;

   assign full    = (lvl_q == (AW+1)'(DEPTH));
   assign empty   = (lvl_q == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign dout    = mem_q[rd_q];
   assign level   = lvl_q;

   always_ff @(posedge baud_clk or negedge arst_n) begin
      if (!arst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         lvl_q <= '0;
      end else begin
         if (push_ok) wr_q <= wr_q + 1'b1;
         if (pop_ok)  rd_q <= rd_q + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   lvl_q <= lvl_q + 1'b1;
            2'b01:   lvl_q <= lvl_q - 1'b1;
            default: lvl_q <= lvl_q;
         endcase
      end
   end

   // Storage needs no reset: entries are only read once written.
   always_ff @(posedge baud_clk) begin
      if (push_ok) mem_q[wr_q] <= din;
   end

endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmit framer, one serial bit per baud_clk edge.
// Frame: start(0), cfg_data_len data bits, optional parity, 1 or 2 stops(1).
// Optional input FIFO enabled by defining UART_TX_FIFO_EN.
//   baud_clk, arst_n      : bit clock, async active-low reset
//   s_valid/s_ready/s_data: character handshake (accepted on valid && ready)
//   cfg_data_len          : 5..DATA_W data bits (others mean DATA_W)
//   cfg_parity            : 0 none, 1 even, 2 odd, 3 mark, 4 space, else none
//   cfg_stop2             : two stop bits when set
//   cfg_msb_first         : bit order select
//   break_req             : hold line low; ends with a single stop bit
//   tx                    : registered serial output, idles high
//   tx_active             : high from start bit through last stop bit
//   tx_done               : one-cycle pulse with the last stop bit
//   fifo_level            : FIFO occupancy (0 without the FIFO)
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          baud_clk,
   input  logic                          arst_n,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic [DATA_W-1:0]             s_data,
   input  logic [3:0]                    cfg_data_len,
   input  logic [2:0]                    cfg_parity,
   input  logic                          cfg_stop2,
   input  logic                          cfg_msb_first,
   input  logic                          break_req,
   output logic                          tx,
   output logic                          tx_active,
   output logic                          tx_done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
   tx_state_e         state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [3:0]        len_q, len_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [2:0]        pmode_q, pmode_d;
   logic              stop2_q, stop2_d;
   logic              msb_q, msb_d;
   logic              brk_q, brk_d;
   logic              par_q, par_d;
   logic              tx_q, tx_d;
   logic              act_q, done_q;

   logic              last_stop, avail, start_frame, cur_bit;
   logic [DATA_W-1:0] frm_data, sh;
   logic [3:0]        idx;

   // A stop following a break is always the final one.
   assign last_stop = (state_q == S_STOP1 && (!stop2_q || brk_q)) ||
                      (state_q == S_STOP2);
   assign start_frame = avail && ((state_q == S_IDLE && !break_req) || last_stop);

`ifdef UART_TX_FIFO_EN
   logic              f_full, f_empty, f_push, f_pop;
   logic [DATA_W-1:0] f_dout;

   assign s_ready  = !f_full;
   assign avail    = s_valid || !f_empty;
   // Empty FIFO at frame start: the incoming character bypasses storage so
   // latency matches the direct path.
   assign frm_data = f_empty ? s_data : f_dout;
   assign f_pop    = start_frame && !f_empty;
   assign f_push   = s_valid && !(start_frame && f_empty);

   uart_tx_fifo #(
      .W     (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .baud_clk (baud_clk),
      .arst_n   (arst_n),
      .push     (f_push),
      .pop      (f_pop),
      .din      (s_data),
      .dout     (f_dout),
      .full     (f_full),
      .empty    (f_empty),
      .level    (fifo_level)
   );
`else
   assign s_ready    = (state_q == S_IDLE && !break_req) || last_stop;
   assign avail      = s_valid;
   assign frm_data   = s_data;
   assign fifo_level = '0;
`endif

   // Counter runs len-1..0; LSB-first maps it back to an ascending index.
   assign idx     = msb_q ? cnt_q : (len_q - 4'd1 - cnt_q);
   assign sh      = data_q >> idx;
   assign cur_bit = sh[0];

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      pmode_d = pmode_q;
      stop2_d = stop2_q;
      msb_d   = msb_q;
      brk_d   = brk_q;
      par_d   = par_q;

      case (state_q)
         S_IDLE: begin
            if (break_req)  state_d = S_BREAK;
            else if (avail) state_d = S_START;
         end
         S_START: begin
            state_d = S_DATA;
            cnt_d   = len_q - 4'd1;
            par_d   = 1'b0;
         end
         S_DATA: begin
            par_d = par_q ^ cur_bit;
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd0)
               state_d = (pmode_q == PAR_NONE) ? S_STOP1 : S_PARITY;
         end
         S_PARITY: state_d = S_STOP1;
         S_STOP1: begin
            if (stop2_q && !brk_q) state_d = S_STOP2;
            else                   state_d = start_frame ? S_START : S_IDLE;
         end
         S_STOP2: state_d = start_frame ? S_START : S_IDLE;
         S_BREAK: begin
            if (!break_req) begin
               state_d = S_STOP1;
               brk_d   = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Everything about the frame is captured as it starts.
      if (start_frame) begin
         data_d  = frm_data;
         len_d   = clamp_len(cfg_data_len, DATA_W);
         pmode_d = (cfg_parity > PAR_SPACE) ? PAR_NONE : cfg_parity;
         stop2_d = cfg_stop2;
         msb_d   = cfg_msb_first;
         brk_d   = 1'b0;
      end
   end

   // Line value for the bit the FSM is presenting; registered one cycle later.
   always_comb begin
      tx_d = 1'b1;
      case (state_q)
         S_START, S_BREAK: tx_d = 1'b0;
         S_DATA:           tx_d = cur_bit;
         S_PARITY: begin
            case (pmode_q)
               PAR_EVEN: tx_d = par_q;
               PAR_ODD:  tx_d = !par_q;
               PAR_MARK: tx_d = 1'b1;
               default:  tx_d = 1'b0;
            endcase
         end
         default:          tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge baud_clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         len_q   <= 4'(DATA_W);
         cnt_q   <= '0;
         pmode_q <= PAR_NONE;
         stop2_q <= 1'b0;
         msb_q   <= 1'b0;
         brk_q   <= 1'b0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         act_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         pmode_q <= pmode_d;
         stop2_q <= stop2_d;
         msb_q   <= msb_d;
         brk_q   <= brk_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         act_q   <= (state_q != S_IDLE);
         done_q  <= last_stop;
      end
   end

   assign tx        = tx_q;
   assign tx_active = act_q;
   assign tx_done   = done_q;

endmodule
